// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : alu_arb_pkg
// Purpose  : Shared state encoding and ALU op codes for the ALU request arbiter.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
package alu_arb_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      WAIT_RDY  = 3'd4
   } arb_state_e;

   localparam logic [2:0] NO_OP  = 3'b000;
   localparam logic [2:0] ADD_OP = 3'b001;
   localparam logic [2:0] AND_OP = 3'b010;
   localparam logic [2:0] XOR_OP = 3'b011;
   localparam logic [2:0] MUL_OP = 3'b100;
   localparam logic [2:0] RST_OP = 3'b111;

   // Only arithmetic/logic ops return a result and raise ALU done.
   function automatic logic has_result(input logic [2:0] op);
      return (op >= ADD_OP) && (op <= MUL_OP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : alu_rr_pick
// Purpose  : Round-robin picker: first asserted request at/after the pointer.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module alu_rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [IDW-1:0]     ptr_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [IDW-1:0]     grant_o,
   output logic               any_o
);

   localparam int IW1 = IDW + 1;

   logic [IW1-1:0] w_idx;

   // Scan from the farthest offset down so the nearest request wins last.
   always_comb begin
      grant_o = ptr_i;
      w_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, ptr_i} + IW1'(k);
         if (w_idx >= IW1'(NUM_REQ)) begin
            w_idx = w_idx - IW1'(NUM_REQ);
         end
         if (req_i[w_idx[IDW-1:0]]) begin
            grant_o = w_idx[IDW-1:0];
         end
      end
   end

   assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : alu_req_arbiter
// Purpose  : Shares one ALU among NUM_REQ requesters, round-robin, one op in
//            flight, result routed to the owner, watchdog on hung ALU.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module alu_req_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int OP_WIDTH     = 8,
   parameter int RESULT_WIDTH = 16,
   parameter int TIMEOUT      = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [3*NUM_REQ-1:0]        req_op_i,
   input  logic [OP_WIDTH*NUM_REQ-1:0] req_a_i,
   input  logic [OP_WIDTH*NUM_REQ-1:0] req_b_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic [NUM_REQ-1:0]          rsp_done_o,
   output logic [RESULT_WIDTH-1:0]     rsp_result_o,
   output logic                        alu_valid_o,
   output logic [2:0]                  alu_op_o,
   output logic [OP_WIDTH-1:0]         alu_a_o,
   output logic [OP_WIDTH-1:0]         alu_b_o,
   input  logic                        alu_ready_i,
   input  logic                        alu_done_i,
   input  logic [RESULT_WIDTH-1:0]     alu_result_i,
   output logic                        busy_o,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id_o,
   output logic                        timeout_err_o
);

   localparam int                 IDW     = $clog2(NUM_REQ);
   localparam int                 WDW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [IDW-1:0]     LAST_ID = IDW'(NUM_REQ - 1);
   localparam logic [WDW-1:0]     WD_LAST = WDW'(TIMEOUT - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);

   arb_state_e                state_q;
   logic [IDW-1:0]            ptr_q;
   logic [IDW-1:0]            id_q;
   logic [WDW-1:0]            wd_q;
   logic [2:0]                op_q;
   logic [OP_WIDTH-1:0]       a_q;
   logic [OP_WIDTH-1:0]       b_q;
   logic                      alu_valid_q;
   logic [NUM_REQ-1:0]        req_ready_q;
   logic [NUM_REQ-1:0]        rsp_done_q;
   logic [RESULT_WIDTH-1:0]   rsp_result_q;
   logic                      busy_q;
   logic                      timeout_err_q;

   logic [IDW-1:0]            w_gnt;
   logic                      w_any;
   logic [2:0]                w_op;
   logic [OP_WIDTH-1:0]       w_a;
   logic [OP_WIDTH-1:0]       w_b;

   alu_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .ptr_i   (ptr_q),
      .req_i   (req_valid_i),
      .grant_o (w_gnt),
      .any_o   (w_any)
   );

   always_comb begin
      w_op = '0;
      w_a  = '0;
      w_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt == IDW'(i)) begin
            w_op = req_op_i[3*i +: 3];
            w_a  = req_a_i[OP_WIDTH*i +: OP_WIDTH];
            w_b  = req_b_i[OP_WIDTH*i +: OP_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         id_q          <= '0;
         wd_q          <= '0;
         op_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         alu_valid_q   <= 1'b0;
         req_ready_q   <= '0;
         rsp_done_q    <= '0;
         rsp_result_q  <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         req_ready_q   <= '0;
         rsp_done_q    <= '0;
         timeout_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (alu_ready_i && w_any) begin
                  id_q        <= w_gnt;
                  op_q        <= w_op;
                  a_q         <= w_a;
                  b_q         <= w_b;
                  alu_valid_q <= 1'b1;
                  req_ready_q <= ONE_HOT << w_gnt;
                  busy_q      <= 1'b1;
                  state_q     <= ISSUE;
               end
            end
            ISSUE: begin
               alu_valid_q <= 1'b0;
               ptr_q       <= (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
               wd_q        <= '0;
               state_q     <= WAIT_BUSY;
            end
            default: begin
               wd_q <= wd_q + WDW'(1);
               // An aborted op is not retried; the pointer already moved on.
               if (wd_q == WD_LAST) begin
                  timeout_err_q <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= IDLE;
               end else begin
                  case (state_q)
                     WAIT_BUSY: begin
                        if (!alu_ready_i) begin
                           state_q <= has_result(op_q) ? WAIT_DONE : WAIT_RDY;
                        end
                     end
                     WAIT_DONE: begin
                        if (alu_done_i) begin
                           rsp_done_q   <= ONE_HOT << id_q;
                           rsp_result_q <= alu_result_i;
                           if (alu_ready_i) begin
                              busy_q  <= 1'b0;
                              state_q <= IDLE;
                           end else begin
                              state_q <= WAIT_RDY;
                           end
                        end
                     end
                     WAIT_RDY: begin
                        if (alu_ready_i) begin
                           busy_q  <= 1'b0;
                           state_q <= IDLE;
                        end
                     end
                     default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   assign req_ready_o   = req_ready_q;
   assign rsp_done_o    = rsp_done_q;
   assign rsp_result_o  = rsp_result_q;
   assign alu_valid_o   = alu_valid_q;
   assign alu_op_o      = op_q;
   assign alu_a_o       = a_q;
   assign alu_b_o       = b_q;
   assign busy_o        = busy_q;
   assign grant_id_o    = id_q;
   assign timeout_err_o = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module   : tb_alu_req_arbiter
// Purpose  : Directed self-checking bench for alu_req_arbiter with an ALU model.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_alu_req_arbiter;
   import alu_arb_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int OPW     = 8;
   localparam int RW      = 16;
   localparam int TIMEOUT = 16;
   localparam int LAT     = 3;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [NUM_REQ-1:0]     req_valid = '0;
   logic [3*NUM_REQ-1:0]   req_op = '0;
   logic [OPW*NUM_REQ-1:0] req_a = '0;
   logic [OPW*NUM_REQ-1:0] req_b = '0;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ-1:0]     rsp_done;
   logic [RW-1:0]          rsp_result;
   logic                   alu_valid;
   logic [2:0]             alu_op;
   logic [OPW-1:0]         alu_a;
   logic [OPW-1:0]         alu_b;
   logic                   alu_rdy_m = 1'b1;
   logic                   alu_block = 1'b0;
   logic                   alu_hang  = 1'b0;
   logic                   alu_done  = 1'b0;
   logic [RW-1:0]          alu_result = '0;
   logic                   alu_ready;
   logic                   busy;
   logic [1:0]             grant_id;
   logic                   timeout_err;

   assign alu_ready = alu_rdy_m & ~alu_block;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int gq[$];
   int rq[$];
   logic [RW-1:0] rr[$];
   int av_cnt = 0, to_cnt = 0, viol = 0, t_valid = 0, t_to = 0;
   logic [NUM_REQ-1:0] acked = '0;
   logic [2:0]     m_op = '0;
   logic [OPW-1:0] m_a = '0, m_b = '0;

   alu_req_arbiter #(
      .NUM_REQ(NUM_REQ), .OP_WIDTH(OPW), .RESULT_WIDTH(RW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
      .req_ready_o(req_ready), .rsp_done_o(rsp_done), .rsp_result_o(rsp_result),
      .alu_valid_o(alu_valid), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_ready_i(alu_ready), .alu_done_i(alu_done), .alu_result_i(alu_result),
      .busy_o(busy), .grant_id_o(grant_id), .timeout_err_o(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic int idx_of(input logic [NUM_REQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Requester agents and response recorder.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if ($countones(req_ready) > 1 || $countones(rsp_done) > 1) viol++;
            if (req_ready != '0) begin
               gq.push_back(idx_of(req_ready));
               acked     = acked | req_ready;
               req_valid = req_valid & ~req_ready;
            end
            if (rsp_done != '0) begin
               rq.push_back(idx_of(rsp_done));
               rr.push_back(rsp_result);
            end
            if (alu_valid) begin av_cnt++; t_valid = cyc; end
            if (timeout_err) begin to_cnt++; t_to = cyc; end
         end
      end
   end

   // ALU model: drops ready after accept, completes after LAT cycles.
   initial begin
      logic hang;
      forever begin
         @(posedge clk);
         if (alu_valid) begin
            m_op = alu_op; m_a = alu_a; m_b = alu_b; hang = alu_hang;
            @(negedge clk);
            alu_rdy_m = 1'b0;
            if (hang) begin
               repeat (TIMEOUT + 4) @(negedge clk);
               alu_rdy_m = 1'b1;
            end else begin
               repeat (LAT) @(negedge clk);
               case (m_op)
                  ADD_OP:  begin alu_done = 1'b1; alu_result = RW'(m_a) + RW'(m_b); end
                  AND_OP:  begin alu_done = 1'b1; alu_result = RW'(m_a & m_b); end
                  XOR_OP:  begin alu_done = 1'b1; alu_result = RW'(m_a ^ m_b); end
                  MUL_OP:  begin alu_done = 1'b1; alu_result = RW'(m_a) * RW'(m_b); end
                  NO_OP, RST_OP: alu_done = 1'b0;
                  default: alu_done = 1'b0;
               endcase
               alu_rdy_m = 1'b1;
               @(negedge clk);
               alu_done = 1'b0;
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[3*i +: 3]   = op;
      req_a[OPW*i +: OPW] = a;
      req_b[OPW*i +: OPW] = b;
      req_valid[i]       = 1'b1;
   endtask

   task automatic clear_log();
      gq.delete(); rq.delete(); rr.delete();
      av_cnt = 0; to_cnt = 0;
   endtask

   task automatic wait_rsp(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk); #1;
         if (rq.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_idle(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk); #1;
         if (gq.size() >= n && !busy && alu_ready) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
      n_checks++; if (alu_valid !== 1'b0) $display("FAIL reset_alu_valid: got %0b want 0", alu_valid); else n_pass++;
      n_checks++; if ({req_ready, rsp_done} !== 8'h00) $display("FAIL reset_ready_done: got %h want 00", {req_ready, rsp_done}); else n_pass++;
      n_checks++; if ({alu_op, alu_a, alu_b} !== 19'h0) $display("FAIL reset_alu_bus: got %h want 0", {alu_op, alu_a, alu_b}); else n_pass++;
      n_checks++; if ({rsp_result, grant_id, timeout_err} !== 19'h0) $display("FAIL reset_misc: got %h want 0", {rsp_result, grant_id, timeout_err}); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_add();
      bit ok;
      clear_log();
      set_req(0, ADD_OP, 8'h05, 8'h03);
      wait_rsp(1, ok);
      n_checks++; if (!ok) $display("FAIL add_rsp_wait: got %0d responses want 1", rq.size()); else n_pass++;
      wait_idle(1, ok);
      n_checks++; if (av_cnt !== 1) $display("FAIL add_valid_width: got %0d cycles want 1", av_cnt); else n_pass++;
      n_checks++; if ({m_op, m_a, m_b} !== {ADD_OP, 8'h05, 8'h03}) $display("FAIL add_alu_bus: got %h want %h", {m_op, m_a, m_b}, {ADD_OP, 8'h05, 8'h03}); else n_pass++;
      n_checks++; if ((rq.size() > 0 ? rq[0] : -1) !== 0) $display("FAIL add_rsp_id: got %0d want 0", (rq.size() > 0 ? rq[0] : -1)); else n_pass++;
      n_checks++; if ((rr.size() > 0 ? rr[0] : 16'hxxxx) !== 16'h0008) $display("FAIL add_result: got %h want 0008", (rr.size() > 0 ? rr[0] : 16'hxxxx)); else n_pass++;
   endtask

   task automatic test_round_robin();
      bit ok;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      clear_log();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, MUL_OP, 8'hFF, 8'hFF);
      wait_rsp(4, ok);
      n_checks++; if (!ok) $display("FAIL rr_rsp_wait: got %0d responses want 4", rq.size()); else n_pass++;
      wait_idle(4, ok);
      for (int i = 0; i < NUM_REQ; i++) begin
         n_checks++; if ((i < gq.size() ? gq[i] : -1) !== i) $display("FAIL rr_grant%0d: got %0d want %0d", i, (i < gq.size() ? gq[i] : -1), i); else n_pass++;
         n_checks++; if ((i < rq.size() ? rq[i] : -1) !== i) $display("FAIL rr_rsp_id%0d: got %0d want %0d", i, (i < rq.size() ? rq[i] : -1), i); else n_pass++;
         n_checks++; if ((i < rr.size() ? rr[i] : 16'hxxxx) !== 16'hFE01) $display("FAIL rr_result%0d: got %h want FE01", i, (i < rr.size() ? rr[i] : 16'hxxxx)); else n_pass++;
      end
   endtask

   task automatic test_no_result();
      bit ok;
      clear_log();
      set_req(2, NO_OP, 8'h12, 8'h34);
      wait_idle(1, ok);
      repeat (LAT + 2) @(negedge clk);
      n_checks++; if ((gq.size() > 0 ? gq[0] : -1) !== 2) $display("FAIL noop_grant: got %0d want 2", (gq.size() > 0 ? gq[0] : -1)); else n_pass++;
      n_checks++; if (rq.size() !== 0) $display("FAIL noop_no_done: got %0d responses want 0", rq.size()); else n_pass++;
      set_req(2, XOR_OP, 8'hF0, 8'h0F);
      wait_rsp(1, ok);
      n_checks++; if ((rq.size() > 0 ? rq[0] : -1) !== 2) $display("FAIL xor_rsp_id: got %0d want 2", (rq.size() > 0 ? rq[0] : -1)); else n_pass++;
      n_checks++; if ((rr.size() > 0 ? rr[0] : 16'hxxxx) !== 16'h00FF) $display("FAIL xor_result: got %h want 00FF", (rr.size() > 0 ? rr[0] : 16'hxxxx)); else n_pass++;
      wait_idle(2, ok);
   endtask

   task automatic test_timeout();
      bit ok;
      clear_log();
      alu_hang = 1'b1;
      set_req(1, ADD_OP, 8'h10, 8'h20);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk); #1;
         if (to_cnt > 0) begin ok = 1'b1; break; end
      end
      alu_hang = 1'b0;
      n_checks++; if (!ok) $display("FAIL to_seen: got %0d pulses want 1", to_cnt); else n_pass++;
      n_checks++; if ((t_to - t_valid) !== TIMEOUT + 1) $display("FAIL to_latency: got %0d want %0d", t_to - t_valid, TIMEOUT + 1); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL to_idle: got busy %0b want 0", busy); else n_pass++;
      set_req(0, ADD_OP, 8'h01, 8'h02);
      wait_rsp(1, ok);
      wait_idle(2, ok);
      n_checks++; if (to_cnt !== 1) $display("FAIL to_pulse_count: got %0d want 1", to_cnt); else n_pass++;
      n_checks++; if ((rq.size() > 0 ? rq[0] : -1) !== 0) $display("FAIL to_next_grant: got %0d want 0", (rq.size() > 0 ? rq[0] : -1)); else n_pass++;
      n_checks++; if ((rr.size() > 0 ? rr[0] : 16'hxxxx) !== 16'h0003) $display("FAIL to_next_result: got %h want 0003", (rr.size() > 0 ? rr[0] : 16'hxxxx)); else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      clear_log();
      set_req(1, MUL_OP, 8'h02, 8'h03);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk); #1;
         if (gq.size() > 0 && !alu_ready) begin ok = 1'b1; break; end
      end
      n_checks++; if (!ok) $display("FAIL mid_accept: got %0d grants want 1", gq.size()); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0b want 0", busy); else n_pass++;
      n_checks++; if (grant_id !== 2'd0) $display("FAIL mid_grant_id: got %0d want 0", grant_id); else n_pass++;
      n_checks++; if ({alu_op, alu_a, alu_b} !== 19'h0) $display("FAIL mid_alu_bus: got %h want 0", {alu_op, alu_a, alu_b}); else n_pass++;
      n_checks++; if (rsp_result !== 16'h0000) $display("FAIL mid_result: got %h want 0000", rsp_result); else n_pass++;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      repeat (12) @(negedge clk);
      n_checks++; if (rq.size() !== 0) $display("FAIL mid_late_done: got %0d responses want 0", rq.size()); else n_pass++;
   endtask

   task automatic test_drop_valid();
      bit ok;
      clear_log();
      acked = '0;
      alu_block = 1'b1;
      set_req(1, ADD_OP, 8'h01, 8'h01);
      set_req(3, AND_OP, 8'hF0, 8'h3C);
      repeat (3) @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      alu_block = 1'b0;
      wait_rsp(1, ok);
      wait_idle(1, ok);
      repeat (5) @(negedge clk);
      n_checks++; if (gq.size() !== 1) $display("FAIL drop_grant_count: got %0d want 1", gq.size()); else n_pass++;
      n_checks++; if ((gq.size() > 0 ? gq[0] : -1) !== 3) $display("FAIL drop_grant_id: got %0d want 3", (gq.size() > 0 ? gq[0] : -1)); else n_pass++;
      n_checks++; if ((rr.size() > 0 ? rr[0] : 16'hxxxx) !== 16'h0030) $display("FAIL drop_result: got %h want 0030", (rr.size() > 0 ? rr[0] : 16'hxxxx)); else n_pass++;
      n_checks++; if (acked[1] !== 1'b0) $display("FAIL drop_req1_acked: got %0b want 0", acked[1]); else n_pass++;
   endtask

   task automatic test_one_hot();
      n_checks++; if (viol !== 0) $display("FAIL one_hot: got %0d multi-bit cycles want 0", viol); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_round_robin();
      test_no_result();
      test_timeout();
      test_reset_mid_op();
      test_drop_valid();
      test_one_hot();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got %0d checks done want completion", n_checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
